corr_frame_source: RTL

Framing and buffering stage directly upstream of the DOA correlation processor. Accepts a continuous, non-stallable two-channel complex sample stream (channel x, channel y) from the ADC front end. Groups it into frames of FRAME_LEN snapshots and presents the frames as paired x/y valid/last streams to the complex-multiplier inputs. A small FIFO absorbs the multiplier's backpressure, and overflow is detected and reported rather than silently corrupting a frame.

---
 rtl/corr_frame_source.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/corr_frame_source.sv
// corr_frame_source: groups a continuous two-channel complex snapshot stream
// into FRAME_LEN-snapshot frames and presents them, through a small show-ahead
// FIFO, as paired x/y valid/last streams. FIFO overflow is reported (sticky)
// and halts capture instead of corrupting a frame.
module corr_frame_source #(
    parameter int DATA_WIDTH_BITS = 12,
    parameter int FRAME_LEN       = 1024,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_s_valid,
    input  logic [DATA_WIDTH_BITS-1:0] i_s_x_r,
    input  logic [DATA_WIDTH_BITS-1:0] i_s_x_c,
    input  logic [DATA_WIDTH_BITS-1:0] i_s_y_r,
    input  logic [DATA_WIDTH_BITS-1:0] i_s_y_c,
    input  logic                       i_ready_x,
    input  logic                       i_ready_y,
    output logic                       o_x_valid,
    output logic                       o_y_valid,
    output logic                       o_x_last,
    output logic                       o_y_last,
    output logic [DATA_WIDTH_BITS-1:0] o_x_r,
    output logic [DATA_WIDTH_BITS-1:0] o_x_c,
    output logic [DATA_WIDTH_BITS-1:0] o_y_r,
    output logic [DATA_WIDTH_BITS-1:0] o_y_c,
    output logic                       o_overflow,
    output logic                       o_frame_done,
    output logic [15:0]                o_frame_cnt,
    output logic                       o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int W  = DATA_WIDTH_BITS;
    localparam int EW = 1 + 4 * W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_in_cnt, w_in_cnt_nxt;
    logic          r_overflow, w_overflow_nxt;
    logic [15:0]   r_frame_cnt;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_valid;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_wr_last;
    logic [EW-1:0] w_wr_data;
    logic [EW-1:0] w_head;
    logic          w_done;

    // Full is taken from the registered count, so a same-cycle pop never frees room for a write.
    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid & i_ready_x & i_ready_y;
    assign w_wr_data = {w_wr_last, i_s_x_r, i_s_x_c, i_s_y_r, i_s_y_c};
    // Head is forced to zero while empty so outputs read 0 after reset.
    assign w_head    = w_valid ? r_mem[r_rd_ptr] : '0;
    assign w_done    = w_pop & w_head[EW-1];

    // Capture FSM next-state, write enable, frame position and overflow flag.
    always_comb begin
        w_state_nxt    = r_state;
        w_in_cnt_nxt   = r_in_cnt;
        w_overflow_nxt = r_overflow;
        w_wr_en        = 1'b0;
        w_wr_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state_nxt    = ST_RUN;
                    w_in_cnt_nxt   = '0;
                    w_overflow_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_s_valid && !w_full) begin
                    w_wr_en = 1'b1;
                    if (r_in_cnt == CW'(FRAME_LEN - 1)) begin
                        w_wr_last    = 1'b1;
                        w_in_cnt_nxt = '0;
                        if (!i_enable) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_in_cnt_nxt = r_in_cnt + CW'(1);
                    end
                end else if (i_s_valid) begin
                    w_overflow_nxt = 1'b1;
                    w_state_nxt    = ST_HALT;
                end else if (!i_enable && (r_in_cnt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture state, frame position and overflow registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_in_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_cnt   <= w_in_cnt_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // FIFO storage; contents need no reset because the head is gated by occupancy.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // FIFO pointers and occupancy; write and pop together leave occupancy unchanged.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Count of frames whose last snapshot has been transferred downstream.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_frame_cnt <= '0;
        end else if (w_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_x_valid    = w_valid;
    assign o_y_valid    = w_valid;
    assign o_x_last     = w_head[EW-1];
    assign o_y_last     = w_head[EW-1];
    assign o_x_r        = w_head[4*W-1:3*W];
    assign o_x_c        = w_head[3*W-1:2*W];
    assign o_y_r        = w_head[2*W-1:W];
    assign o_y_c        = w_head[W-1:0];
    assign o_overflow   = r_overflow;
    assign o_frame_done = w_done;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_busy       = (r_state != ST_IDLE) || w_valid;

endmodule
